id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_hazard_detect.sv | 18 +
 rtl/id_ex_stage.sv | 68 ++++++
 tb/tb_id_ex_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline definitions (control bundle layout, bubble, forwarding selects)
package id_ex_stage_pkg;
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   localparam int CTRL_MEMREAD  = 2;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_ALUSRC   = 4;
   localparam int CTRL_REGDST   = 5;
   localparam int CTRL_ALUOP_LO = 6;
   localparam int CTRL_ALUOP_HI = 7;
   localparam logic [7:0] CTRL_BUBBLE = 8'h00;
   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_e;
   typedef struct packed {
      logic        valid;
      logic [7:0]  ctrl;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
   } id_ex_t;
   localparam id_ex_t ID_EX_BUBBLE = '{
      valid: 1'b0, ctrl: CTRL_BUBBLE, rs_addr: 5'd0, rt_addr: 5'd0, rd_addr: 5'd0,
      rs_data: 32'd0, rt_data: 32'd0, imm: 32'd0
   };
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use compare between the EX load and the ID consumer
module hazard_detect
   import id_ex_stage_pkg::*;
(
   input  logic       id_valid,
   input  logic       flush,
   input  logic       ex_valid,
   input  logic [7:0] ex_ctrl,
   input  logic [4:0] ex_rt_addr,
   input  logic [4:0] id_rs_addr,
   input  logic [4:0] id_rt_addr,
   output logic       hazard
);
   // a load targeting $0 produces nothing to wait for, and a flushed slot never stalls
   assign hazard = id_valid && !flush && ex_valid && ex_ctrl[CTRL_MEMREAD] &&
                   (ex_rt_addr != 5'd0) &&
                   ((ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and stall counter
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter logic [15:0] cnt_max = 16'hFFFF
)
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs_addr_i,
   input  logic [4:0]  id_rt_addr_i,
   input  logic [4:0]  id_rd_addr_i,
   input  logic [31:0] id_rs_data_i,
   input  logic [31:0] id_rt_data_i,
   input  logic [31:0] id_imm_i,
   input  logic [7:0]  id_ctrl_i,
   input  logic        flush_i,
   output logic        ex_valid_o,
   output logic [7:0]  ex_ctrl_o,
   output logic [4:0]  ex_rs_addr_o,
   output logic [4:0]  ex_rt_addr_o,
   output logic [4:0]  ex_rd_addr_o,
   output logic [31:0] ex_rs_data_o,
   output logic [31:0] ex_rt_data_o,
   output logic [31:0] ex_imm_o,
   output logic        hazard_o,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic [15:0] stall_cnt_o
);
   id_ex_t ex_q;
   id_ex_t id_d;
   assign id_d = '{
      valid: id_valid_i, ctrl: id_ctrl_i, rs_addr: id_rs_addr_i, rt_addr: id_rt_addr_i,
      rd_addr: id_rd_addr_i, rs_data: id_rs_data_i, rt_data: id_rt_data_i, imm: id_imm_i
   };
   hazard_detect u_hazard_detect (
      .id_valid  (id_valid_i),
      .flush     (flush_i),
      .ex_valid  (ex_q.valid),
      .ex_ctrl   (ex_q.ctrl),
      .ex_rt_addr(ex_q.rt_addr),
      .id_rs_addr(id_rs_addr_i),
      .id_rt_addr(id_rt_addr_i),
      .hazard    (hazard_o)
   );
   assign pc_write_o   = !hazard_o;
   assign ifid_write_o = !hazard_o;
   // a bubble clears memread, so the held consumer cannot re-trigger the stall next cycle
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         ex_q        <= ID_EX_BUBBLE;
         stall_cnt_o <= 16'd0;
      end else begin
         ex_q <= (flush_i || hazard_o) ? ID_EX_BUBBLE : id_d;
         if (hazard_o && stall_cnt_o != cnt_max)
            stall_cnt_o <= stall_cnt_o + 16'd1;
      end
   assign ex_valid_o   = ex_q.valid;
   assign ex_ctrl_o    = ex_q.ctrl;
   assign ex_rs_addr_o = ex_q.rs_addr;
   assign ex_rt_addr_o = ex_q.rt_addr;
   assign ex_rd_addr_o = ex_q.rd_addr;
   assign ex_rs_data_o = ex_q.rs_data;
   assign ex_rt_data_o = ex_q.rt_data;
   assign ex_imm_o     = ex_q.imm;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed checks of id_ex_stage against a cycle-level reference model
module tb_id_ex_stage;
   localparam logic [15:0] CNT_MAX = 16'd40;
   localparam logic [7:0]  LW = 8'h17;
   localparam logic [7:0]  ADD = 8'hA1;
   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   logic id_valid_i = 1'b0, flush_i = 1'b0;
   logic [4:0] id_rs_addr_i = '0, id_rt_addr_i = '0, id_rd_addr_i = '0;
   logic [31:0] id_rs_data_i = '0, id_rt_data_i = '0, id_imm_i = '0;
   logic [7:0] id_ctrl_i = '0;
   logic ex_valid_o, hazard_o, pc_write_o, ifid_write_o;
   logic [7:0] ex_ctrl_o;
   logic [4:0] ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
   logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
   logic [15:0] stall_cnt_o;
   int errors = 0, checks = 0;
   logic m_valid;
   logic [7:0] m_ctrl;
   logic [4:0] m_rs, m_rt, m_rd;
   logic [31:0] m_rsd, m_rtd, m_imm;
   logic [15:0] m_cnt;
   logic seen_hz, seen_pcw;
   id_ex_stage #(.cnt_max(CNT_MAX)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
      .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_ctrl_i(id_ctrl_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
      .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
      .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
      .hazard_o(hazard_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
      .stall_cnt_o(stall_cnt_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model_clear(input logic clr_cnt);
      {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm} = '0;
      if (clr_cnt) m_cnt = '0;
   endtask
   task automatic check_regs(input string tag);
      check({tag, "_valid"}, 32'(ex_valid_o), 32'(m_valid));
      check({tag, "_ctrl"}, 32'(ex_ctrl_o), 32'(m_ctrl));
      check({tag, "_rs"}, 32'(ex_rs_addr_o), 32'(m_rs));
      check({tag, "_rt"}, 32'(ex_rt_addr_o), 32'(m_rt));
      check({tag, "_rd"}, 32'(ex_rd_addr_o), 32'(m_rd));
      check({tag, "_rsd"}, ex_rs_data_o, m_rsd);
      check({tag, "_rtd"}, ex_rt_data_o, m_rtd);
      check({tag, "_imm"}, ex_imm_o, m_imm);
      check({tag, "_cnt"}, 32'(stall_cnt_o), 32'(m_cnt));
   endtask
   // one clock: drive at negedge, check combinational outputs, advance model, check registers
   task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [7:0] c, input logic fl);
      logic hz;
      @(negedge clk_i);
      id_valid_i = v; id_rs_addr_i = rs; id_rt_addr_i = rt; id_rd_addr_i = rd;
      id_ctrl_i = c; flush_i = fl;
      id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
      #1;
      hz = v && !fl && m_valid && m_ctrl[2] && m_rt != 5'd0 && (m_rt == rs || m_rt == rt);
      seen_hz = hazard_o;
      seen_pcw = pc_write_o;
      check("hazard", 32'(hazard_o), 32'(hz));
      check("pc_write", 32'(pc_write_o), 32'(!hz));
      check("ifid_write", 32'(ifid_write_o), 32'(!hz));
      @(posedge clk_i);
      if (fl || hz) model_clear(1'b0);
      else begin
         m_valid = v; m_ctrl = c; m_rs = rs; m_rt = rt; m_rd = rd;
         m_rsd = id_rs_data_i; m_rtd = id_rt_data_i; m_imm = id_imm_i;
      end
      if (hz && m_cnt != CNT_MAX) m_cnt++;
      #1 check_regs("reg");
   endtask
   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      #1 model_clear(1'b1);
      check_regs("rst");
      check("rst_pcw", 32'(pc_write_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask
   initial begin
      model_clear(1'b1);
      #12;
      check_regs("por");
      check("por_hz", 32'(hazard_o), 32'd0);
      check("por_pcw", 32'(pc_write_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cyc(1, 5'd1, 5'd5, 5'd0, LW, 0);
      cyc(1, 5'd5, 5'd7, 5'd6, ADD, 0);
      check("029_hz", 32'(seen_hz), 32'd1);
      check("029_pcw", 32'(seen_pcw), 32'd0);
      check("029_bubble", 32'(ex_ctrl_o), 32'd0);
      cyc(1, 5'd5, 5'd7, 5'd6, ADD, 0);
      check("029_hz2", 32'(seen_hz), 32'd0);
      check("029_add", 32'(ex_ctrl_o), 32'(ADD));
      check("029_cnt", 32'(stall_cnt_o), 32'd1);
      do_reset();
      cyc(1, 5'd1, 5'd0, 5'd0, LW, 0);
      cyc(1, 5'd0, 5'd0, 5'd4, ADD, 0);
      check("030_hz", 32'(seen_hz), 32'd0);
      check("030_cnt", 32'(stall_cnt_o), 32'd0);
      cyc(1, 5'd1, 5'd5, 5'd0, LW, 0);
      cyc(1, 5'd5, 5'd7, 5'd6, ADD, 1);
      check("031_hz", 32'(seen_hz), 32'd0);
      check("031_pcw", 32'(seen_pcw), 32'd1);
      check("031_valid", 32'(ex_valid_o), 32'd0);
      check("031_cnt", 32'(stall_cnt_o), 32'd0);
      do_reset();
      cyc(1, 5'd0, 5'd1, 5'd0, LW, 0);
      cyc(1, 5'd0, 5'd2, 5'd0, LW, 0);
      check("032_hz_lw", 32'(seen_hz), 32'd0);
      cyc(1, 5'd2, 5'd1, 5'd3, ADD, 0);
      check("032_hz_add", 32'(seen_hz), 32'd1);
      cyc(1, 5'd2, 5'd1, 5'd3, ADD, 0);
      check("032_cnt", 32'(stall_cnt_o), 32'd1);
      cyc(1, 5'd1, 5'd5, 5'd0, LW, 0);
      cyc(0, 5'd5, 5'd5, 5'd9, ADD, 0);
      check("023_hz", 32'(seen_hz), 32'd0);
      check("023_ctrl", 32'(ex_ctrl_o), 32'(ADD));
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 8'($urandom) | ($urandom_range(0, 1) ? 8'h04 : 8'h00),
             $urandom_range(0, 7) == 0);
      do_reset();
      for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
         cyc(1, 5'd1, 5'd5, 5'd0, LW, 0);
         cyc(1, 5'd5, 5'd7, 5'd6, ADD, 0);
      end
      check("033_sat", 32'(stall_cnt_o), 32'(CNT_MAX));
      cyc(1, 5'd1, 5'd5, 5'd0, LW, 0);
      @(negedge clk_i);
      id_valid_i = 1; id_rs_addr_i = 5'd5; id_rt_addr_i = 5'd7; id_ctrl_i = ADD; flush_i = 0;
      #1 check("034_hz_pre", 32'(hazard_o), 32'd1);
      #1 rst_n_i = 1'b0;
      #1 model_clear(1'b1);
      check_regs("034");
      check("034_hz", 32'(hazard_o), 32'd0);
      check("034_pcw", 32'(pc_write_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cyc(1, 5'd5, 5'd7, 5'd6, ADD, 0);
      check("034_after", 32'(ex_ctrl_o), 32'(ADD));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
